and_gate_tt_driver: RTL and testbench

AND_GATE_TT_DRIVER -- requirements
Module: and_gate_tt_driver

---
 rtl/and_gate_tt_driver_if.sv | 43 ++++
 rtl/and_gate_tt_driver.sv | 206 ++++++++++++++++++++
 tb/tb_and_gate_tt_driver.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/and_gate_tt_driver_if.sv
// ============================================================================
//  Module      : and_gate_tt_driver_if
//  Description : Bundles the run handshake, the gate drive and the result
//                signals of the AND-gate truth-table driver.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface and_gate_tt_driver_if;
  logic       start;
  logic       x_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic [7:0] err_cnt;
  logic       pass;

  // master: the driver itself; slave: whoever requests runs and hosts the gate
  modport master (
    input  start,
    input  x_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output err_cnt,
    output pass
  );

  modport slave (
    output start,
    output x_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  err_cnt,
    input  pass
  );
endinterface

`default_nettype wire

// File: rtl/and_gate_tt_driver.sv
// ============================================================================
//  Module      : and_gate_tt_driver
//  Description : Walks a 2-input AND gate through its truth table LOOPS times,
//                comparing the gate output once per vector; counts mismatches.
//                Optional macro AND_GATE_TT_STABLE_CHK_EN adds a per-vector
//                x_in stability check during SETTLE/CHECK.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module and_gate_tt_driver #(
  parameter int HOLD  = 2,
  parameter int LOOPS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  and_gate_tt_driver_if.master  bus
);

  localparam logic [3:0] HOLD_M1   = 4'(HOLD - 1);
  localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] loop_q, loop_d;
  logic [3:0] hold_q, hold_d;

  logic       mismatch;
  logic       unstable_chk;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [1:0] vec_inc;

  // Any value other than the ideal AND result, including X/Z, is a mismatch
  assign mismatch = (bus.x_in !== (a_q & b_q));
  assign vec_inc  = vec_q + 2'd1;

`ifdef AND_GATE_TT_STABLE_CHK_EN
  logic stable_q, stable_d;
  logic x_prev_q, x_prev_d;
  logic first_sample;

  always_comb begin
    stable_d     = stable_q;
    x_prev_d     = x_prev_q;
    first_sample = ((state_q == SETTLE) && (hold_q == 4'd1)) ||
                   ((state_q == CHECK) && (HOLD == 1));
    if (state_q == DRIVE) begin
      stable_d = 1'b1;
    end else if ((state_q == SETTLE) || (state_q == CHECK)) begin
      x_prev_d = bus.x_in;
      if (!first_sample && (bus.x_in !== x_prev_q)) begin
        stable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b1;
      x_prev_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      x_prev_q <= x_prev_d;
    end
  end

  // Includes the CHECK-cycle sample itself
  assign unstable_chk = ~stable_d;
`else
  assign unstable_chk = 1'b0;
`endif

  always_comb begin
    err_inc = {1'b0, mismatch} + {1'b0, unstable_chk};
    err_sum = {1'b0, err_q} + {7'd0, err_inc};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    pass_d  = pass_q;
    vec_d   = vec_q;
    loop_d  = loop_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          loop_d  = 8'd0;
          hold_d  = 4'd0;
          err_d   = 8'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      DRIVE: begin
        hold_d  = 4'd1;
        state_d = (HOLD == 1) ? CHECK : SETTLE;
      end

      SETTLE: begin
        if (hold_q == HOLD_M1) begin
          state_d = CHECK;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      CHECK: begin
        hold_d = 4'd0;
        err_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
        if (vec_q != 2'd3) begin
          state_d = DRIVE;
          vec_d   = vec_inc;
          a_d     = vec_inc[1];
          b_d     = vec_inc[0];
        end else if (loop_q != LOOP_LAST) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          loop_d  = loop_q + 8'd1;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end
      end

      DONE: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end

      default: begin
        state_d = IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 8'd0;
      pass_q  <= 1'b0;
      vec_q   <= 2'd0;
      loop_q  <= 8'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.a_out   = a_q;
  assign bus.b_out   = b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_and_gate_tt_driver.sv
// ============================================================================
//  Module      : tb_and_gate_tt_driver
//  Description : Self-checking bench for and_gate_tt_driver (three parameter
//                sets) against a timeline-based truth-table reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and_gate_tt_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]  start_v;
  logic [2:0]  x_v;
  logic [2:0]  a_v, b_v, busy_v, done_v, pass_v;
  logic [23:0] err_all;

  int n_vec = 0;
  int n_mis = 0;

  and_gate_tt_driver_if if0 ();
  and_gate_tt_driver_if if1 ();
  and_gate_tt_driver_if if2 ();

  and_gate_tt_driver #(.HOLD(2), .LOOPS(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  and_gate_tt_driver #(.HOLD(1), .LOOPS(255)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  and_gate_tt_driver #(.HOLD(3), .LOOPS(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.x_in  = x_v[0];
  assign if1.x_in  = x_v[1];
  assign if2.x_in  = x_v[2];

  assign a_v    = {if2.a_out, if1.a_out, if0.a_out};
  assign b_v    = {if2.b_out, if1.b_out, if0.b_out};
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  assign pass_v = {if2.pass, if1.pass, if0.pass};
  assign err_all = {if2.err_cnt, if1.err_cnt, if0.err_cnt};

  function automatic int hold_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 3;
  endfunction

  function automatic int loops_of(input int d);
    return (d == 1) ? 255 : 1;
  endfunction

  function automatic int err_of(input int d);
    return int'(err_all[d*8 +: 8]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    chk({tag, "_a"},    32'(a_v[d]), 0);
    chk({tag, "_b"},    32'(b_v[d]), 0);
    chk({tag, "_busy"}, 32'(busy_v[d]), 0);
    chk({tag, "_done"}, 32'(done_v[d]), 0);
    chk({tag, "_err"},  32'(err_of(d)), 0);
    chk({tag, "_pass"}, 32'(pass_v[d]), 0);
  endtask

  // Modes: 0 ideal gate, 1 stuck-at-1, 2 stuck-at-0, 3 ideal with random
  // flips, 4 glitch 1->0->1 on vector 11, 5 fully random x_in.
  task automatic run(input int d, input int mode, input bit keep_start, output int res);
    int  h, l, n, vec, p, inc, exp_err;
    bit  x, ideal, prev, have_prev, unstable;
    h = hold_of(d);
    l = loops_of(d);
    n = 4 * (h + 1) * l;
    exp_err   = 0;
    prev      = 1'b0;
    have_prev = 1'b0;
    unstable  = 1'b0;
    start_v[d] = 1'b1;
    tick();
    if (!keep_start) start_v[d] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      vec = ((k - 1) / (h + 1)) % 4;
      p   = (k - 1) % (h + 1);
      chk("run_a",    32'(a_v[d]), 32'(vec / 2));
      chk("run_b",    32'(b_v[d]), 32'(vec % 2));
      chk("run_busy", 32'(busy_v[d]), 1);
      chk("run_done", 32'(done_v[d]), 0);
      chk("run_err",  32'(err_of(d)), 32'(exp_err));
      ideal = (vec == 3);
      case (mode)
        0:       x = ideal;
        1:       x = 1'b1;
        2:       x = 1'b0;
        3:       x = ($urandom_range(0, 7) == 0) ? !ideal : ideal;
        4:       x = (vec == 3 && p == 1) ? 1'b0 : ideal;
        default: x = 1'($urandom_range(0, 1));
      endcase
      x_v[d] = x;
      if (p == 0) begin
        have_prev = 1'b0;
        unstable  = 1'b0;
      end else begin
        if (have_prev && (x != prev)) unstable = 1'b1;
        prev      = x;
        have_prev = 1'b1;
      end
      if (p == h) begin
        inc = (x != ideal) ? 1 : 0;
`ifdef AND_GATE_TT_STABLE_CHK_EN
        if (unstable) inc++;
`endif
        exp_err = (exp_err + inc > 255) ? 255 : exp_err + inc;
      end
      tick();
    end
    chk("done_pulse", 32'(done_v[d]), 1);
    chk("done_busy",  32'(busy_v[d]), 0);
    chk("done_err",   32'(err_of(d)), 32'(exp_err));
    chk("done_pass",  32'(pass_v[d]), 32'(exp_err == 0));
    tick();
    chk("idle_done",  32'(done_v[d]), 0);
    chk("idle_busy",  32'(busy_v[d]), 0);
    chk("idle_a",     32'(a_v[d]), 0);
    chk("idle_b",     32'(b_v[d]), 0);
    chk("idle_err",   32'(err_of(d)), 32'(exp_err));
    chk("idle_pass",  32'(pass_v[d]), 32'(exp_err == 0));
    res = exp_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst     = 1'b1;
    start_v = 3'b000;
    x_v     = 3'b000;
    tick();
    start_v = 3'b111;
    tick();
    tick();
    for (int d = 0; d < 3; d++) chk_idle_zero(d, "reset");
    start_v = 3'b000;
    rst     = 1'b0;
    tick();

    // Ideal gate: clean pass
    run(0, 0, 1'b0, r);
    chk("ideal_err",  32'(err_of(0)), 0);
    chk("ideal_pass", 32'(pass_v[0]), 1);

    // Stuck-at-1 output: vectors 00, 01, 10 fail
    run(0, 1, 1'b0, r);
    chk("stuck1_err",  32'(err_of(0)), 3);
    chk("stuck1_pass", 32'(pass_v[0]), 0);

    for (int i = 0; i < 4; i++) begin
      run(0, 3, 1'b0, r);
      run(0, 5, 1'b0, r);
    end

    // Reset during the third vector aborts with no done pulse
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      x_v[0] = (k > 9);
      tick();
    end
    chk("abort_a", 32'(a_v[0]), 1);
    chk("abort_b", 32'(b_v[0]), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero(0, "abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_nodone", 32'(done_v[0]), 0);
      chk("abort_nobusy", 32'(busy_v[0]), 0);
    end
    run(0, 0, 1'b0, r);
    chk("restart_pass", 32'(pass_v[0]), 1);

    // start held through a run: a new run begins only after IDLE
    run(0, 3, 1'b1, r);
    tick();
    chk("rehold_busy", 32'(busy_v[0]), 1);
    chk("rehold_err",  32'(err_of(0)), 0);
    chk("rehold_a",    32'(a_v[0]), 0);
    start_v[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero(0, "rehold_rst");

    // HOLD=1, LOOPS=255: stuck-at-0 gives exactly one miss per pass
    run(1, 2, 1'b0, r);
    chk("sat_stuck0_err", 32'(err_of(1)), 255);
    run(1, 1, 1'b0, r);
    chk("sat_stuck1_err", 32'(err_of(1)), 255);
    run(1, 5, 1'b0, r);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_hold_err",  32'(err_of(1)), 32'(r));
      chk("sat_hold_pass", 32'(pass_v[1]), 32'(r == 0));
    end

    // HOLD=3 glitch on vector 11
    run(2, 4, 1'b0, r);
`ifdef AND_GATE_TT_STABLE_CHK_EN
    chk("glitch_err", 32'(err_of(2)), 1);
`else
    chk("glitch_err", 32'(err_of(2)), 0);
`endif
    for (int i = 0; i < 4; i++) run(2, 5, 1'b0, r);
    run(2, 0, 1'b0, r);
    chk("h3_ideal_pass", 32'(pass_v[2]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
